// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding, default sizes and weight-address helper for the SNN event controller
package snn_pkg;
  typedef enum logic [1:0] {IDLE, WEIGHT_LOAD, ACCUM, FIRE} ctrl_state_t;
  localparam int DEF_N_INPUTS = 16;
  localparam int DEF_N_NEURONS = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_EVT_CNT_W = 16;
  function automatic int unsigned waddr_cat(int unsigned evt, int unsigned cnt, int unsigned cnt_w);
    return (evt << cnt_w) | cnt;
  endfunction
endpackage

// File: rtl/snn_event_fifo.sv
// snn_event_fifo: parametrised synchronous FIFO with async active-high reset
module snn_event_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o = mem_q[rp_q];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/snn_event_controller.sv
// snn_event_controller: queues input spikes, bursts weights per event, fires at timestep end
module snn_event_controller
  import snn_pkg::*;
#(
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int EVT_CNT_W = DEF_EVT_CNT_W,
  localparam int EVT_W = $clog2(N_INPUTS),
  localparam int CNT_W = $clog2(N_NEURONS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   event_valid_i,
  input  logic [EVT_W-1:0]       event_addr_i,
  output logic                   event_ready_o,
  input  logic                   timestep_end_i,
  output logic                   weight_w_en_o,
  output logic [EVT_W+CNT_W-1:0] weight_addr_o,
  output logic                   accum_en_o,
  output logic                   fire_en_o,
  output logic                   busy_o,
  output logic [EVT_CNT_W-1:0]   event_count_o
);
  ctrl_state_t state_q, state_d;
  logic [EVT_W-1:0] cur_q, cur_d, head;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EVT_CNT_W-1:0] run_q, run_d, evc_q, evc_d;
  logic fp_q, fp_d, full, empty, pop;
  assign pop = (state_q == IDLE) & ~empty;
  // Held low during reset so the source cannot push into a FIFO that is being cleared
  assign event_ready_o = ~full & ~rst_i;
  snn_event_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(event_valid_i & event_ready_o), .pop_i(pop),
    .din_i(event_addr_i), .dout_o(head), .full_o(full), .empty_o(empty)
  );
  assign weight_w_en_o = state_q == WEIGHT_LOAD;
  assign accum_en_o = state_q == ACCUM;
  assign fire_en_o = state_q == FIRE;
  assign busy_o = (state_q != IDLE) | ~empty | fp_q;
  assign event_count_o = evc_q;
  assign weight_addr_o = (EVT_W+CNT_W)'(waddr_cat(32'(cur_q), 32'(cnt_q), CNT_W));
  // A new timestep_end wins over the clear on leaving FIRE
  assign fp_d = timestep_end_i | (fp_q & (state_q != FIRE));
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    cnt_d = cnt_q;
    run_d = run_q;
    evc_d = evc_q;
    case (state_q)
      IDLE: if (!empty) begin
        state_d = WEIGHT_LOAD;
        cur_d = head;
        cnt_d = '0;
      end else if (fp_q) state_d = FIRE;
      WEIGHT_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_NEURONS - 1)) state_d = ACCUM;
      end
      ACCUM: begin
        run_d = run_q + EVT_CNT_W'(run_q != '1);
        state_d = IDLE;
      end
      FIRE: begin
        evc_d = run_q;
        run_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      cur_q <= '0;
      cnt_q <= '0;
      run_q <= '0;
      evc_q <= '0;
      fp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      evc_q <= evc_d;
      fp_q <= fp_d;
    end
endmodule

// File: doc/snn_event_controller.md
Name: snn_event_controller

Overview:
- Parametrised event-driven controller for one SNN core.
- Buffers incoming input-spike events in a small FIFO with a valid/ready handshake.
- For each event, sequences a weight burst over all neurons, then a one-cycle accumulate strobe.
- On a timestep boundary, drains all queued events, then issues a one-cycle fire strobe (threshold compare/reset in the neuron array) and reports the per-timestep event count.

Parameters:
N_INPUTS, 16, number of input (pre-synaptic) lines; power of two, >= 2
N_NEURONS, 16, neurons per core = weight words per event; power of two, >= 2
FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2
EVT_CNT_W, 16, width of per-timestep event counter
(derived) EVT_W = $clog2(N_INPUTS), CNT_W = $clog2(N_NEURONS)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
event_valid  in  1  source presents an event
event_addr  in  EVT_W  index of spiking input
event_ready  out  1  FIFO can accept; transfer on valid && ready at rising edge
timestep_end  in  1  one-cycle pulse marking end of timestep
weight_w_en  out  1  weight word valid for neuron array
weight_addr  out  EVT_W+CNT_W  {current_event, neuron_cnt}
accum_en  out  1  one-cycle accumulate strobe after each burst
fire_en  out  1  one-cycle fire/threshold strobe at timestep end
busy  out  1  state != IDLE or FIFO non-empty or fire pending
event_count  out  EVT_CNT_W  events processed in the last completed timestep

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, FIFO emptied, neuron_cnt=0, fire_pending=0, event_count=0, internal running count=0.
  - weight_w_en=accum_en=fire_en=0, busy=0.
  - event_ready=0 while reset is high; event_ready=1 from the first cycle after release.
  - Reset mid-burst or mid-queue discards all in-flight and queued events; no partial accum_en is issued.
- FIFO:
  - event_ready = !full.
  - A push at full cannot happen; source must hold valid until ready.
  - Simultaneous push and pop allowed when not full; occupancy is unchanged.
  - Order is strict FIFO.
- fire_pending:
  - Set by timestep_end.
  - Cleared when the controller leaves FIRE.
  - A timestep_end coinciding with the clear leaves it set (set wins).
  - Repeated pulses while pending are absorbed as one.
- FSM states: IDLE, WEIGHT_LOAD, ACCUM, FIRE.
  - IDLE:
    - If FIFO non-empty: pop head into current_event, neuron_cnt=0, go to WEIGHT_LOAD.
    - Else if fire_pending: go to FIRE.
    - Else stay.
    - Events take priority over fire; fire occurs only when the FIFO is empty.
  - WEIGHT_LOAD:
    - weight_w_en=1, weight_addr={current_event, neuron_cnt}.
    - neuron_cnt increments each cycle; exactly N_NEURONS cycles, addresses 0..N_NEURONS-1 in order.
    - At neuron_cnt==N_NEURONS-1: neuron_cnt wraps to 0, go to ACCUM.
  - ACCUM:
    - accum_en=1 for one cycle, running count +1 (saturating at all-ones), go to IDLE.
  - FIRE:
    - fire_en=1 for one cycle.
    - event_count <= running count; running count <= 0; go to IDLE.
- Latency and throughput:
  - Event accepted at edge E with controller idle and FIFO empty: first weight_w_en in the cycle after edge E+1.
  - accum_en follows the last weight word by exactly one cycle.
  - Sustained throughput is one event per N_NEURONS+2 cycles.
- Events accepted while in FIRE are counted in the next timestep.
- weight_addr is don't-care when weight_w_en=0 but is driven (no X).
- Illegal state encoding returns to IDLE.

Decomposition:
- snn_pkg holds:
  - ctrl_state_t enum {IDLE, WEIGHT_LOAD, ACCUM, FIRE}
  - default parameter constants
  - function for weight address concatenation
- One sub-module: snn_event_fifo (parametrised sync FIFO; ports push/pop/din/dout/full/empty, async active-high reset).

Test Plan:
- Single event, defaults: event_addr=3 accepted while idle -> 16 cycles weight_w_en with weight_addr 0x30..0x3F in order, then exactly one accum_en; busy drops the following cycle.
- Back-to-back burst: hold valid for addrs 1,2,3,4,5 -> ready drops after 4 queued plus 1 in service; five bursts in order, each 18 cycles apart; no event lost or duplicated.
- Timestep with backlog: 3 events queued, timestep_end pulsed during first burst -> all 3 bursts complete before fire_en; fire_en single cycle; event_count=3 afterwards.
- Set-wins boundary: timestep_end pulsed in the same cycle fire_en is high -> a second fire_en follows; event_count=0 after it.
- Reset mid-burst: reset asserted at neuron_cnt=7 -> outputs zero immediately (async), no accum_en; after release, FIFO is empty and a new event starts at neuron 0.
- Parameter sweep: N_INPUTS=64, N_NEURONS=8, FIFO_DEPTH=2 -> weight_addr is 9 bits, 8-word bursts, ready low after 2 queued.
